// File: rtl/dds_word_loader_pkg.sv
// rtl/dds_word_loader_pkg.sv - shared command codes, frame length and FSM encoding
package dds_word_loader_pkg;

    localparam logic [7:0] CMD_FWORD   = 8'h01;
    localparam logic [7:0] CMD_PWORD   = 8'h02;
    localparam logic [7:0] CMD_COMMIT  = 8'h03;
    localparam logic [7:0] CMD_DEFAULT = 8'h04;

    localparam int         FRAME_BITS  = 40;
    localparam logic [5:0] FRAME_LEN   = 6'd40;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WAIT_STB = 2'd3
    } state_t;

endpackage

// File: rtl/dds_sync_edge.sv
// rtl/dds_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
module dds_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    // STAGES must be at least 2; the chain slice below relies on it.
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/dds_word_loader.sv
// rtl/dds_word_loader.sv - SPI frame receiver loading DDS frequency/phase words
module dds_word_loader
    import dds_word_loader_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] FWORD_RST   = 32'd0,
    parameter logic [15:0] PWORD_RST   = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    input  logic        strobe,
    output logic [31:0] FWORD,
    output logic [15:0] PWORD,
    output logic        pending,
    output logic        frame_err
);

    logic                  w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic                  w_cs_q, w_cs_rise, w_cs_fall;
    logic                  w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic                  w_unused_sync;

    state_t                r_state, w_state_nxt;
    logic [5:0]            r_cnt;
    logic                  r_ovr;
    logic [FRAME_BITS-1:0] r_shift;
    logic [31:0]           r_fsh;
    logic [15:0]           r_psh;
    logic                  r_pending;
    logic                  r_frame_err;

    logic [7:0]            w_cmd;
    logic [31:0]           w_data;
    logic                  w_clr_cnt, w_shift, w_err, w_load_out, w_default;
    logic                  w_pending_nxt;
    logic [31:0]           w_fsh_nxt;
    logic [15:0]           w_psh_nxt;

    dds_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    dds_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_d(cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    dds_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_d(mosi),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_sync = ^{w_sclk_q, w_sclk_fall, w_cs_q, w_mosi_rise, w_mosi_fall};

    assign w_cmd  = r_shift[39:32];
    assign w_data = r_shift[31:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Command decode, strobe commit and next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt     = 1'b0;
        w_shift       = 1'b0;
        w_err         = 1'b0;
        w_load_out    = 1'b0;
        w_default     = 1'b0;
        w_pending_nxt = r_pending;
        w_fsh_nxt     = r_fsh;
        w_psh_nxt     = r_psh;

        // A pending commit fires on strobe in any state, so a frame can run alongside it.
        if (r_pending && strobe) begin
            w_load_out    = 1'b1;
            w_pending_nxt = 1'b0;
        end

        if (r_state == ST_EXEC) begin
            case (w_cmd)
                CMD_FWORD:   w_fsh_nxt = w_data;
                CMD_PWORD:   w_psh_nxt = w_data[15:0];
                CMD_COMMIT: begin
                    if (w_data[0]) w_pending_nxt = 1'b1;
                    else           w_load_out    = 1'b1;
                end
                CMD_DEFAULT: begin
                    w_default     = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_fsh_nxt     = FWORD_RST;
                    w_psh_nxt     = PWORD_RST;
                end
                default:     w_err = 1'b1;
            endcase
        end

        case (r_state)
            ST_IDLE, ST_WAIT_STB: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clr_cnt   = 1'b1;
                end else if (w_pending_nxt) begin
                    w_state_nxt = ST_WAIT_STB;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    if (r_cnt == FRAME_LEN && !r_ovr) begin
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = w_pending_nxt ? ST_WAIT_STB : ST_IDLE;
                    end
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                end
            end
            ST_EXEC: w_state_nxt = w_pending_nxt ? ST_WAIT_STB : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter, overrun flag and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 6'd0;
            r_ovr   <= 1'b0;
            r_shift <= '0;
        end else if (w_clr_cnt) begin
            r_cnt <= 6'd0;
            r_ovr <= 1'b0;
        end else if (w_shift) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_q};
            if (r_cnt == FRAME_LEN) r_ovr <= 1'b1;
            else                    r_cnt <= r_cnt + 6'd1;
        end
    end

    // Shadow registers, pending flag and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsh       <= FWORD_RST;
            r_psh       <= PWORD_RST;
            r_pending   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_fsh       <= w_fsh_nxt;
            r_psh       <= w_psh_nxt;
            r_pending   <= w_pending_nxt;
            r_frame_err <= w_err;
        end
    end

    // Output words always update together: from a commit or a default restore
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FWORD <= FWORD_RST;
            PWORD <= PWORD_RST;
        end else if (w_default) begin
            FWORD <= FWORD_RST;
            PWORD <= PWORD_RST;
        end else if (w_load_out) begin
            FWORD <= w_fsh_nxt;
            PWORD <= w_psh_nxt;
        end
    end

    assign pending   = r_pending;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_dds_word_loader.sv
// tb/tb_dds_word_loader.sv - randomized self-checking bench with reference model
module tb_dds_word_loader;

    localparam logic [31:0] FRST = 32'h1234_5678;
    localparam logic [15:0] PRST = 16'hABCD;

    logic        clk = 1'b0;
    logic        rst_n, sclk, cs_n, mosi, strobe;
    logic [31:0] FWORD;
    logic [15:0] PWORD;
    logic        pending, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_err_seen = 0;

    // reference model state
    logic [31:0] m_f, m_sf;
    logic [15:0] m_p, m_sp;
    logic        m_pend;
    int          m_err;

    dds_word_loader #(.SYNC_STAGES(2), .FWORD_RST(FRST), .PWORD_RST(PRST)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .strobe(strobe), .FWORD(FWORD), .PWORD(PWORD),
        .pending(pending), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && frame_err) n_err_seen++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_f = FRST; m_sf = FRST; m_p = PRST; m_sp = PRST; m_pend = 1'b0;
    endtask

    task automatic model_frame(input int n, input logic [7:0] c, input logic [31:0] d);
        if (n != 40) begin
            m_err++;
        end else begin
            case (c)
                8'h01: m_sf = d;
                8'h02: m_sp = d[15:0];
                8'h03: if (d[0]) m_pend = 1'b1; else begin m_f = m_sf; m_p = m_sp; end
                8'h04: begin model_reset(); end
                default: m_err++;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".fword"},   FWORD,      m_f);
        check({tag, ".pword"},   PWORD,      m_p);
        check({tag, ".pending"}, pending,    m_pend);
        check({tag, ".errs"},    n_err_seen, m_err);
    endtask

    // Shift n bits MSB first (bits past 40 are zero); abort_at >= 0 asserts reset after that many bits
    task automatic send_frame(input int n, input logic [7:0] c, input logic [31:0] d, input int abort_at);
        logic [39:0] w;
        w = {c, d};
        cs_n = 1'b0;
        #60;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid.fword",   FWORD,   FRST);
                check("rst_mid.pword",   PWORD,   PRST);
                check("rst_mid.pending", pending, 1'b0);
                model_reset();
                cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
                #19 rst_n = 1'b1;
                #100;
                return;
            end
            mosi = (i < 40) ? w[39-i] : 1'b0;
            #30 sclk = 1'b1;
            #30 sclk = 1'b0;
        end
        #30 cs_n = 1'b1;
        #200;
        model_frame(n, c, d);
    endtask

    task automatic pulse_strobe(input string tag);
        @(posedge clk); #2;
        check({tag, ".pre_fword"}, FWORD, m_f);
        strobe = 1'b1;
        @(posedge clk); #2;
        strobe = 1'b0;
        if (m_pend) begin m_f = m_sf; m_p = m_sp; m_pend = 1'b0; end
        compare_all(tag);
    endtask

    initial begin
        logic [31:0] f_before;
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; strobe = 1'b0;
        m_err = 0;
        model_reset();
        #11;
        compare_all("reset");
        #9 rst_n = 1'b1;
        #40;

        // basic load and immediate commit
        send_frame(40, 8'h01, 32'h000D1B72, -1);
        send_frame(40, 8'h02, 32'h00000800, -1);
        compare_all("shadow_only");
        send_frame(40, 8'h03, 32'h00000000, -1);
        compare_all("commit_now");
        check("commit_now.f_lit", FWORD, 32'h000D1B72);
        check("commit_now.p_lit", PWORD, 16'h0800);

        // synchronous commit waits 50 cycles for strobe
        send_frame(40, 8'h01, 32'h0BAD_F00D, -1);
        send_frame(40, 8'h03, 32'h00000001, -1);
        f_before = FWORD;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            check("wait.pending", pending, 1'b1);
            check("wait.fword",   FWORD,   f_before);
        end
        pulse_strobe("sync_commit");
        check("sync_commit.f_lit", FWORD, 32'h0BAD_F00D);

        // malformed frames
        send_frame(39, 8'h01, 32'hDEAD_BEEF, -1);
        compare_all("short39");
        send_frame(41, 8'h01, 32'hDEAD_BEEF, -1);
        compare_all("long41");
        send_frame(40, 8'h03, 32'h0, -1);
        compare_all("after_bad_commit");

        // newest shadow wins for a pending commit
        send_frame(40, 8'h03, 32'h1, -1);
        send_frame(40, 8'h01, 32'hC5B00005, -1);
        compare_all("update_in_wait");
        pulse_strobe("newest_shadow");
        check("newest_shadow.f_lit", FWORD, 32'hC5B00005);

        // default command cancels pending commit
        send_frame(40, 8'h01, 32'h7777_0000, -1);
        send_frame(40, 8'h03, 32'h1, -1);
        send_frame(40, 8'h04, 32'h0, -1);
        compare_all("default_in_wait");
        pulse_strobe("strobe_after_default");

        // reset mid-frame, then a clean frame
        send_frame(40, 8'h01, 32'h5555_AAAA, 20);
        compare_all("after_rst");
        send_frame(40, 8'h01, 32'h0F0F_1234, -1);
        send_frame(40, 8'h03, 32'h0, -1);
        compare_all("post_rst_frame");

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int sel, len;
            logic [7:0]  c;
            logic [31:0] d;
            sel = $urandom_range(0, 9);
            d   = $urandom;
            len = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? 41 : 39) : 40;
            case (sel)
                0, 1, 2: c = 8'h01;
                3, 4:    c = 8'h02;
                5, 6:    c = 8'h03;
                7:       c = 8'h04;
                default: c = 8'($urandom_range(5, 255));
            endcase
            if (sel == 9) pulse_strobe("rand_strobe");
            else begin
                send_frame(len, c, d, -1);
                compare_all("rand_frame");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_word_loader.md
DDS_WORD_LOADER -- requirements
Module: dds_word_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the synchronizer depth for sclk, cs_n and mosi (minimum 2).
REQ-002 Parameter FWORD_RST, default 32'd0, is the FWORD output value after reset.
REQ-003 Parameter PWORD_RST, default 16'd0, is the PWORD output value after reset.
REQ-004 clk  in  1  system clock, same domain as the DDS phase accumulator.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sclk  in  1  serial clock from host; asynchronous to clk; period at least 4 clk periods.
REQ-007 cs_n  in  1  frame select, active low, asynchronous.
REQ-008 mosi  in  1  serial data; MSB first; sampled on the rising sclk edge (SPI mode 0).
REQ-009 strobe  in  1  DDS phase marker, single-cycle pulse, clk domain.
REQ-010 FWORD  out  32  frequency control word driven to the DDS.
REQ-011 PWORD  out  16  phase control word driven to the DDS.
REQ-012 pending  out  1  high while a synchronous commit waits for strobe.
REQ-013 frame_err  out  1  one-cycle pulse when a malformed frame is discarded.

Function
REQ-014 sclk, cs_n and mosi SHALL pass through SYNC_STAGES flops; sclk rising and cs_n edges SHALL be detected on the synchronized signals.
REQ-015 A frame SHALL be exactly 40 bits: an 8-bit command followed by a 32-bit data field, shifted MSB first.
REQ-016 The state machine SHALL have the states IDLE, SHIFT, EXEC and WAIT_STB.
REQ-017 IDLE -> SHIFT on the synchronized cs_n falling edge; the 6-bit bit counter SHALL clear.
REQ-018 In SHIFT, each synchronized sclk rise SHALL shift mosi into a 40-bit register and increment the counter; bits beyond 40 SHALL set an overrun flag.
REQ-019 SHIFT -> EXEC on cs_n rise when count == 40 and no overrun; otherwise -> IDLE with a frame_err pulse and no register change.
REQ-020 Command 0x01 SHALL load data[31:0] into the FWORD shadow register.
REQ-021 Command 0x02 SHALL load data[15:0] into the PWORD shadow register; data[31:16] SHALL be ignored.
REQ-022 Command 0x03 with data[0]=0 SHALL copy both shadow registers to FWORD/PWORD in the EXEC cycle.
REQ-023 Command 0x03 with data[0]=1 SHALL go to WAIT_STB with pending=1, and SHALL copy both shadows on the first clk cycle in which strobe=1; outputs change the following cycle.
REQ-024 Command 0x04 SHALL restore both shadow registers and both outputs to FWORD_RST/PWORD_RST and cancel any pending commit.
REQ-025 Any other command SHALL be a no-op with a frame_err pulse.
REQ-026 EXEC SHALL last one cycle and then go to IDLE (or WAIT_STB per REQ-023).
REQ-027 In WAIT_STB, a new frame SHALL be received normally.
REQ-028 A 0x01 or 0x02 frame arriving during WAIT_STB SHALL update the shadows, and the pending commit SHALL use the newest shadows.
REQ-029 A 0x03 frame during WAIT_STB SHALL leave a single commit pending.
REQ-030 FWORD/PWORD SHALL change only by a commit or 0x04, and always together in the same cycle (never torn).
REQ-031 If strobe and a cs_n falling edge coincide in WAIT_STB, the commit SHALL happen and the frame SHALL also start.

Reset
REQ-032 On rst_n low, asynchronously: FWORD=FWORD_RST, PWORD=PWORD_RST, shadows equal to the same values, pending=0, frame_err=0, state=IDLE, counter/shift/overrun cleared, synchronizers set to idle levels (cs_n=1, sclk=0).
REQ-033 Reset mid-frame or in WAIT_STB SHALL abandon the operation; after release, the first accepted frame SHALL begin at the next cs_n falling edge.

Structure
REQ-034 A shared package SHALL hold the command codes (CMD_FWORD=8'h01, CMD_PWORD=8'h02, CMD_COMMIT=8'h03, CMD_DEFAULT=8'h04), the frame length 40, and the state encoding.
REQ-035 One sub-module, dds_sync_edge, SHALL implement the SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated per serial input.

Verification
REQ-036 Frames 0x01/0x000D1B72, 0x02/0x00000800, 0x03/0x00000000 -> FWORD=0x000D1B72 and PWORD=0x0800 one cycle after EXEC; pending stays 0.
REQ-037 Frame 0x03/0x00000001, then strobe pulsed 50 cycles later -> pending=1 for those cycles, outputs unchanged until the cycle after strobe, then pending=0.
REQ-038 39-bit frame and 41-bit frame -> one frame_err pulse each; FWORD/PWORD/shadows unchanged.
REQ-039 Sync commit pending, then 0x01/0xC5B00005 received before strobe -> FWORD=0xC5B00005 after strobe.
REQ-040 rst_n asserted at bit 20 of a frame -> outputs at FWORD_RST/PWORD_RST immediately; the next full frame is accepted correctly.
REQ-041 Command 0x04 during WAIT_STB -> defaults restored, pending=0, later strobe causes no change.
